// File: rtl/tempsens_mon_pkg.sv
// tempsens_mon_pkg: shared types and default parameters for the temperature-sensor monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tempsens_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SRESET,
    CONVERT,
    CAPTURE,
    DRAIN
  } state_e;

  localparam int DefDoutW       = 24;
  localparam int DefAvgLog2     = 2;
  localparam int DefResetCycles = 8;
  localparam int DefTimeoutW    = 20;

  // Width of a counter that must reach n-1. Never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tempsens_monitor_if.sv
// tempsens_monitor_if: bundle between the monitor and the tempsenseInst macro pins.
// Latency: n/a (wires only). Ports: sens_rst_no/sens_en_o/sens_sel_conv_time_o toward
// the sensor; sens_dout_i/sens_done_i back from it. Backpressure: none, the sensor free-runs.
interface tempsens_monitor_if
  import tempsens_mon_pkg::*;
#(
  parameter int DoutW = DefDoutW
);

  logic             sens_rst_no;
  logic             sens_en_o;
  logic [3:0]       sens_sel_conv_time_o;
  logic [DoutW-1:0] sens_dout_i;
  logic             sens_done_i;

  // master: the monitor that sequences the sensor
  modport master (
    output sens_rst_no,
    output sens_en_o,
    output sens_sel_conv_time_o,
    input  sens_dout_i,
    input  sens_done_i
  );

  // slave: the sensor macro (or its model)
  modport slave (
    input  sens_rst_no,
    input  sens_en_o,
    input  sens_sel_conv_time_o,
    output sens_dout_i,
    output sens_done_i
  );

endinterface

// File: rtl/tempsens_mon_sync.sv
// tempsens_mon_sync: 2-flop synchronizer for the sensor DONE line plus registered rising-edge pulse.
// Latency: sync_o follows async_i after 2 clk_i edges, rise_o pulses one edge later (3 edges).
// Backpressure: none. Ports: clk_i, rst_i (async, active-high), async_i in; sync_o, rise_o out.
module tempsens_mon_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  // sync_q[0], sync_q[1] form the synchronizer; sync_q[2] is the delayed copy used for edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 3'b000;
      rise_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      rise_o <= sync_q[1] & ~sync_q[2];
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/tempsens_monitor.sv
// tempsens_monitor: autonomous conversion sequencer for tempsenseInst with sample averaging,
// threshold alarms and a conversion watchdog. Latency: DONE sampled at edge t -> sample/avg
// valid in cycle t+4. Backpressure: none; result pulses are single-cycle and must be taken.
// Ports: clk_i/rst_i; start_i/stop_i/sel_conv_time_i/thr_hi_i/thr_lo_i control; sens (sensor
// bundle, master side); busy_o, sample_valid_o/sample_o, avg_valid_o/avg_o, alarm_hi_o,
// alarm_lo_o, timeout_o status/results.
module tempsens_monitor
  import tempsens_mon_pkg::*;
#(
  parameter int DoutW       = DefDoutW,
  parameter int AvgLog2     = DefAvgLog2,
  parameter int ResetCycles = DefResetCycles,
  parameter int TimeoutW    = DefTimeoutW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [3:0]          sel_conv_time_i,
  input  logic [DoutW-1:0]    thr_hi_i,
  input  logic [DoutW-1:0]    thr_lo_i,
  tempsens_monitor_if.master  sens,
  output logic                busy_o,
  output logic                sample_valid_o,
  output logic [DoutW-1:0]    sample_o,
  output logic                avg_valid_o,
  output logic [DoutW-1:0]    avg_o,
  output logic                alarm_hi_o,
  output logic                alarm_lo_o,
  output logic                timeout_o
);

  localparam int AccW = DoutW + AvgLog2;
  localparam int CntW = (AvgLog2 > 0) ? AvgLog2 : 1;
  localparam int RcW  = cnt_width(ResetCycles);

  localparam logic [CntW-1:0]     CntLast = CntW'((1 << AvgLog2) - 1);
  localparam logic [RcW-1:0]      RcLast  = RcW'(ResetCycles - 1);
  // Watchdog expires on the edge where it would reach 2^TimeoutW-1, i.e. after that many
  // CONVERT cycles; the timeout pulse then lands in the first retry SRESET cycle.
  localparam logic [TimeoutW-1:0] WdLast  = TimeoutW'((1 << TimeoutW) - 2);

  state_e              state_q, state_d;
  logic [3:0]          sel_q;
  logic [AccW-1:0]     acc_q;
  logic [CntW-1:0]     cnt_q;
  logic [TimeoutW-1:0] wd_q;
  logic [RcW-1:0]      rc_q;

  logic                done_sync;
  logic                done_rise;

  logic                sens_rst_n_c;
  logic                sens_en_c;

  logic [AccW-1:0]     sum;
  logic [DoutW-1:0]    avg_now;
  logic                avg_wrap;

  tempsens_mon_sync u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (sens.sens_done_i),
    .sync_o  (done_sync),
    .rise_o  (done_rise)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sens_rst_n_c = 1'b0;
    sens_en_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = SRESET;
      end
      SRESET: begin
        if (rc_q == RcLast) state_d = CONVERT;
      end
      CONVERT: begin
        sens_rst_n_c = 1'b1;
        sens_en_c    = 1'b1;
        // A completed conversion beats a simultaneous watchdog expiry.
        if (done_rise)           state_d = CAPTURE;
        else if (wd_q == WdLast) state_d = SRESET;
      end
      CAPTURE: begin
        sens_rst_n_c = 1'b1;
        sens_en_c    = 1'b1;
        state_d      = DRAIN;
      end
      DRAIN: begin
        // Counter reset stays released so DOUT/DONE are not disturbed until DONE drops.
        sens_rst_n_c = 1'b1;
        if (!done_sync) state_d = SRESET;
      end
      default: state_d = IDLE;
    endcase
    if (stop_i) state_d = IDLE;
  end

  assign busy_o                    = (state_q != IDLE);
  assign sens.sens_rst_no          = sens_rst_n_c;
  assign sens.sens_en_o            = sens_en_c;
  assign sens.sens_sel_conv_time_o = sel_q;

  // ---------------------------------------------------------------------------
  // Datapath: counters, accumulator, results
  // ---------------------------------------------------------------------------
  assign sum      = acc_q + AccW'(sens.sens_dout_i);
  assign avg_now  = DoutW'(sum >> AvgLog2);
  assign avg_wrap = (cnt_q == CntLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q          <= 4'd0;
      acc_q          <= '0;
      cnt_q          <= '0;
      wd_q           <= '0;
      rc_q           <= '0;
      sample_valid_o <= 1'b0;
      sample_o       <= '0;
      avg_valid_o    <= 1'b0;
      avg_o          <= '0;
      alarm_hi_o     <= 1'b0;
      alarm_lo_o     <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      sample_valid_o <= 1'b0;
      avg_valid_o    <= 1'b0;
      timeout_o      <= 1'b0;
      if (stop_i) begin
        // Abort: drop any partial average; results and alarms keep their last values.
        sel_q <= 4'd0;
        acc_q <= '0;
        cnt_q <= '0;
        wd_q  <= '0;
        rc_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              sel_q <= sel_conv_time_i;
              acc_q <= '0;
              cnt_q <= '0;
              wd_q  <= '0;
              rc_q  <= '0;
            end
          end
          SRESET: begin
            wd_q <= '0;
            rc_q <= (rc_q == RcLast) ? '0 : rc_q + 1'b1;
          end
          CONVERT: begin
            if (done_rise) begin
              wd_q <= '0;
            end else if (wd_q == WdLast) begin
              wd_q      <= '0;
              timeout_o <= 1'b1;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          CAPTURE: begin
            sample_o       <= sens.sens_dout_i;
            sample_valid_o <= 1'b1;
            if (avg_wrap) begin
              avg_o       <= avg_now;
              avg_valid_o <= 1'b1;
              alarm_hi_o  <= (avg_now > thr_hi_i);
              alarm_lo_o  <= (avg_now < thr_lo_i);
              acc_q       <= '0;
              cnt_q       <= '0;
            end else begin
              acc_q <= sum;
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tempsens_monitor.sv
// tb_tempsens_monitor: directed bench for tempsens_monitor with a simple sensor model.
// Latency: checks first-sample, average, timeout and stop timing cycle-exactly.
// Backpressure: none; the bench drives DONE and waits with bounded loops.
module tb_tempsens_monitor;

  localparam int DW = 24;

  logic          clk_i;
  logic          rst_i;
  logic          start_i;
  logic          stop_i;
  logic [3:0]    sel_conv_time_i;
  logic [DW-1:0] thr_hi_i;
  logic [DW-1:0] thr_lo_i;
  logic          busy_o;
  logic          sample_valid_o;
  logic [DW-1:0] sample_o;
  logic          avg_valid_o;
  logic [DW-1:0] avg_o;
  logic          alarm_hi_o;
  logic          alarm_lo_o;
  logic          timeout_o;

  int checks = 0;
  int errors = 0;

  tempsens_monitor_if #(.DoutW(DW)) sif ();

  tempsens_monitor #(
    .DoutW       (DW),
    .AvgLog2     (2),
    .ResetCycles (8),
    .TimeoutW    (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .sel_conv_time_i (sel_conv_time_i),
    .thr_hi_i        (thr_hi_i),
    .thr_lo_i        (thr_lo_i),
    .sens            (sif),
    .busy_o          (busy_o),
    .sample_valid_o  (sample_valid_o),
    .sample_o        (sample_o),
    .avg_valid_o     (avg_valid_o),
    .avg_o           (avg_o),
    .alarm_hi_o      (alarm_hi_o),
    .alarm_lo_o      (alarm_lo_o),
    .timeout_o       (timeout_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  // Poll until the sensor is enabled; lands on the first CONVERT cycle.
  task automatic wait_en(input string tag);
    int n;
    n = 0;
    while (sif.sens_en_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk1({tag, " en_wait"}, (n < 40), 1'b1);
  endtask

  // One conversion: raise DONE with val, check sample (and average) timing and values.
  task automatic conv(input string tag, input logic [DW-1:0] val, input logic exp_avg,
                      input logic [DW-1:0] exp_avg_val, input logic exp_hi, input logic exp_lo);
    wait_en(tag);
    sif.sens_dout_i = val;
    sif.sens_done_i = 1'b1;
    repeat (4) tick();
    chk1({tag, " early_sv"}, sample_valid_o, 1'b0);
    tick();
    chk1({tag, " sv"}, sample_valid_o, 1'b1);
    chkw({tag, " sample"}, sample_o, val);
    chk1({tag, " av"}, avg_valid_o, exp_avg);
    chk1({tag, " drain_en"}, sif.sens_en_o, 1'b0);
    if (exp_avg) begin
      chkw({tag, " avg"}, avg_o, exp_avg_val);
      chk1({tag, " alarm_hi"}, alarm_hi_o, exp_hi);
      chk1({tag, " alarm_lo"}, alarm_lo_o, exp_lo);
    end
    tick();
    chk1({tag, " sv_drop"}, sample_valid_o, 1'b0);
    chk1({tag, " av_drop"}, avg_valid_o, 1'b0);
    sif.sens_done_i = 1'b0;
  endtask

  initial begin
    start_i         = 1'b0;
    stop_i          = 1'b0;
    sel_conv_time_i = 4'd0;
    thr_hi_i        = 24'd105;
    thr_lo_i        = 24'd50;
    sif.sens_dout_i = '0;
    sif.sens_done_i = 1'b0;
    rst_i           = 1'b0;
    #1 rst_i = 1'b1;
    #2;

    // Reset values
    chk1("rst sens_rst_no", sif.sens_rst_no, 1'b0);
    chk1("rst sens_en", sif.sens_en_o, 1'b0);
    chkw("rst sel", {20'd0, sif.sens_sel_conv_time_o}, 24'd0);
    chk1("rst busy", busy_o, 1'b0);
    chk1("rst sv", sample_valid_o, 1'b0);
    chk1("rst av", avg_valid_o, 1'b0);
    chkw("rst sample", sample_o, 24'd0);
    chkw("rst avg", avg_o, 24'd0);
    chk1("rst alarm_hi", alarm_hi_o, 1'b0);
    chk1("rst alarm_lo", alarm_lo_o, 1'b0);
    chk1("rst timeout", timeout_o, 1'b0);

    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // Start timing: SRESET cycles 1..8, enable from cycle 9
    sel_conv_time_i = 4'hA;
    pulse_start();
    sel_conv_time_i = 4'h5;
    chk1("start busy", busy_o, 1'b1);
    chk1("start en", sif.sens_en_o, 1'b0);
    chk1("start rst_no", sif.sens_rst_no, 1'b0);
    chkw("start sel", {20'd0, sif.sens_sel_conv_time_o}, 24'hA);
    repeat (7) tick();
    chk1("sreset8 en", sif.sens_en_o, 1'b0);
    chk1("sreset8 rst_no", sif.sens_rst_no, 1'b0);
    tick();
    chk1("convert en", sif.sens_en_o, 1'b1);
    chk1("convert rst_no", sif.sens_rst_no, 1'b1);

    // Basic loop: 100,104,108,112 -> 106, above thr_hi
    conv("s100", 24'd100, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("s104", 24'd104, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("s108", 24'd108, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("s112", 24'd112, 1'b1, 24'd106, 1'b1, 1'b0);

    // Second average: 30,38,42,50 -> 40, below thr_lo
    conv("s30", 24'd30, 1'b0, 24'd0, 1'b0, 1'b0);
    chk1("alarm_hi held", alarm_hi_o, 1'b1);
    chkw("avg held", avg_o, 24'd106);
    conv("s38", 24'd38, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("s42", 24'd42, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("s50", 24'd50, 1'b1, 24'd40, 1'b0, 1'b1);

    // Timeout in the middle of an average: 200, timeout, 204,208,212 -> 206
    conv("s200", 24'd200, 1'b0, 24'd0, 1'b0, 1'b0);
    wait_en("to");
    repeat (14) tick();
    chk1("to conv15 en", sif.sens_en_o, 1'b1);
    chk1("to conv15 timeout", timeout_o, 1'b0);
    tick();
    chk1("to pulse", timeout_o, 1'b1);
    chk1("to retry en", sif.sens_en_o, 1'b0);
    chk1("to retry rst_no", sif.sens_rst_no, 1'b0);
    chk1("to busy", busy_o, 1'b1);
    tick();
    chk1("to pulse_drop", timeout_o, 1'b0);
    repeat (6) tick();
    chk1("to sreset8 en", sif.sens_en_o, 1'b0);
    tick();
    chk1("to reconvert en", sif.sens_en_o, 1'b1);
    conv("s204", 24'd204, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("s208", 24'd208, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("s212", 24'd212, 1'b1, 24'd206, 1'b1, 1'b0);
    chkw("sel latched", {20'd0, sif.sens_sel_conv_time_o}, 24'hA);

    // Full-scale samples must not overflow the accumulator
    conv("max0", 24'hFFFFFF, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("max1", 24'hFFFFFF, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("max2", 24'hFFFFFF, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("max3", 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1, 1'b0);

    // stop_i in the cycle the synced DONE edge reaches the FSM
    wait_en("stopcol");
    sif.sens_dout_i = 24'h000123;
    sif.sens_done_i = 1'b1;
    repeat (3) tick();
    pulse_stop();
    chk1("stopcol busy", busy_o, 1'b0);
    chk1("stopcol en", sif.sens_en_o, 1'b0);
    chk1("stopcol sv", sample_valid_o, 1'b0);
    tick();
    chk1("stopcol sv_late", sample_valid_o, 1'b0);
    chkw("stopcol sample hold", sample_o, 24'hFFFFFF);
    chkw("stopcol avg hold", avg_o, 24'hFFFFFF);
    chk1("stopcol alarm hold", alarm_hi_o, 1'b1);
    chkw("stopcol sel", {20'd0, sif.sens_sel_conv_time_o}, 24'd0);
    sif.sens_done_i = 1'b0;
    tick();

    // Partial accumulation is discarded by stop: 1000 then stop, then 20,24,28,32 -> 26
    pulse_start();
    conv("p1000", 24'd1000, 1'b0, 24'd0, 1'b0, 1'b0);
    pulse_stop();
    chk1("partial busy", busy_o, 1'b0);
    pulse_start();
    chkw("restart sel", {20'd0, sif.sens_sel_conv_time_o}, 24'h5);
    conv("p20", 24'd20, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("p24", 24'd24, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("p28", 24'd28, 1'b0, 24'd0, 1'b0, 1'b0);
    conv("p32", 24'd32, 1'b1, 24'd26, 1'b0, 1'b1);
    pulse_stop();
    tick();

    // start_i and stop_i together in IDLE
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk1("startstop busy", busy_o, 1'b0);
    chk1("startstop en", sif.sens_en_o, 1'b0);
    tick();
    chk1("startstop busy2", busy_o, 1'b0);

    // Asynchronous reset during CONVERT
    pulse_start();
    wait_en("arst");
    rst_i = 1'b1;
    #1;
    chk1("arst busy", busy_o, 1'b0);
    chk1("arst en", sif.sens_en_o, 1'b0);
    chk1("arst rst_no", sif.sens_rst_no, 1'b0);
    chkw("arst sel", {20'd0, sif.sens_sel_conv_time_o}, 24'd0);
    chkw("arst sample", sample_o, 24'd0);
    chkw("arst avg", avg_o, 24'd0);
    chk1("arst alarm_hi", alarm_hi_o, 1'b0);
    chk1("arst alarm_lo", alarm_lo_o, 1'b0);
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    chk1("post-rst busy", busy_o, 1'b0);
    pulse_start();
    chk1("post-rst start busy", busy_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
